// File: rtl/inst_queue_pkg.sv
// Shared definitions for the instruction queue between fetch and decode.
package inst_queue_pkg;

  localparam int IQ_DEPTH = 8;
  localparam int IQ_AW    = 3;

  // Fetch exception tags carried with each instruction.
  localparam logic [1:0] EXCP_NONE = 2'd0;
  localparam logic [1:0] EXCP_ADEF = 2'd1;
  localparam logic [1:0] EXCP_PIF  = 2'd2;

  // One queue entry: 32 + 32 + 1 + 32 + 2 = 99 bits.
  localparam int IQ_W = 99;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [1:0]  excp;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue_iq_ram.sv
// Register array for queue entries: one write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the queue control.
module iq_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int AW    = IQ_AW,
  parameter int W     = IQ_W
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Store the incoming entry at the write pointer.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between IF and ID. Holds head/tail pointers, occupancy count,
// the valid/ready handshakes and redirect flush; entries live in iq_ram.
//
// Handshake: a beat transfers on a side exactly in a cycle where that side's valid
// and ready are both high at the rising clock edge. in_ready depends only on the
// registered count (not on out_ready), out_valid only on the registered count, and
// a flush in the same cycle cancels both transfers.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int AW    = IQ_AW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_inst,
  input  logic          in_pred_taken,
  input  logic [31:0]   in_pred_target,
  input  logic [1:0]    in_excp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_inst,
  output logic          out_pred_taken,
  output logic [31:0]   out_pred_target,
  output logic [1:0]    out_excp,
  output logic [AW:0]   count
);

  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;
  iq_entry_t       w_wentry;
  iq_entry_t       w_rentry;
  logic [IQ_W-1:0] w_rdata;

  assign in_ready  = (r_count != LP_FULL);
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  // Flush wins: the beat offered in a flush cycle is dropped and the head is not consumed.
  assign w_push = in_valid & in_ready & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  assign w_wentry = '{pc:          in_pc,
                      inst:        in_inst,
                      pred_taken:  in_pred_taken,
                      pred_target: in_pred_target,
                      excp:        in_excp};

  iq_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (IQ_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_tail),
    .i_wdata (w_wentry),
    .i_raddr (r_head),
    .o_rdata (w_rdata)
  );

  assign w_rentry = iq_entry_t'(w_rdata);

  // Payload reads zero while empty so uninitialised storage never leaks out;
  // exception entries present a zero instruction word to the decoder.
  assign out_pc          = out_valid ? w_rentry.pc          : 32'd0;
  assign out_pred_taken  = out_valid ? w_rentry.pred_taken  : 1'b0;
  assign out_pred_target = out_valid ? w_rentry.pred_target : 32'd0;
  assign out_excp        = out_valid ? w_rentry.excp        : EXCP_NONE;
  assign out_inst        = (out_valid && (w_rentry.excp == EXCP_NONE)) ? w_rentry.inst : 32'd0;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed scenarios followed by random traffic, all checked
// against an in-order queue model of the instruction buffer.
module tb_inst_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk;
  logic          rstn;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc;
  logic [31:0]   in_inst;
  logic          in_pred_taken;
  logic [31:0]   in_pred_target;
  logic [1:0]    in_excp;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic          out_pred_taken;
  logic [31:0]   out_pred_target;
  logic [1:0]    out_excp;
  logic [AW:0]   count;

  // Reference: entries packed as {pc, inst, pred_taken, pred_target, excp}.
  logic [98:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  inst_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_pc           (in_pc),
    .in_inst         (in_inst),
    .in_pred_taken   (in_pred_taken),
    .in_pred_target  (in_pred_target),
    .in_excp         (in_excp),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_pred_taken  (out_pred_taken),
    .out_pred_target (out_pred_target),
    .out_excp        (out_excp),
    .count           (count)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [98:0] obs, input logic [98:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the model queue.
  task automatic check_outputs();
    int unsigned n;
    logic [98:0] e;
    n = exp_q.size();
    chk("count", 99'(count), 99'(n));
    chk("out_valid", 99'(out_valid), 99'(n != 0));
    chk("in_ready", 99'(in_ready), 99'(n != DEPTH));
    if (n != 0) begin
      e = exp_q[0];
      chk("out_pc", 99'(out_pc), 99'(e[98:67]));
      chk("out_inst", 99'(out_inst), (e[1:0] != 2'd0) ? 99'd0 : 99'(e[66:35]));
      chk("out_pred_taken", 99'(out_pred_taken), 99'(e[34]));
      chk("out_pred_target", 99'(out_pred_target), 99'(e[33:2]));
      chk("out_excp", 99'(out_excp), 99'(e[1:0]));
    end
  endtask

  task automatic idle_inputs();
    in_valid       = 1'b0;
    in_pc          = '0;
    in_inst        = '0;
    in_pred_taken  = 1'b0;
    in_pred_target = '0;
    in_excp        = '0;
    out_ready      = 1'b0;
    flush          = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance the model by the queue rules, then check.
  task automatic beat(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic pt, input logic [31:0] tgt, input logic [1:0] ex,
                      input logic ordy, input logic fl);
    bit acc;
    bit dq;
    logic [98:0] dropped;
    in_valid       = v;
    in_pc          = pc;
    in_inst        = inst;
    in_pred_taken  = pt;
    in_pred_target = tgt;
    in_excp        = ex;
    out_ready      = ordy;
    flush          = fl;
    acc = v && (exp_q.size() < DEPTH) && !fl;
    dq  = ordy && (exp_q.size() > 0) && !fl;
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (dq) dropped = exp_q.pop_front();
      if (acc) exp_q.push_back({pc, inst, pt, tgt, ex});
    end
    idle_inputs();
    check_outputs();
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic ordy);
    beat(1'b1, pc, inst, 1'b0, 32'd0, 2'd0, ordy, 1'b0);
  endtask

  task automatic wait_cycle(input logic ordy);
    beat(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 2'd0, ordy, 1'b0);
  endtask

  initial begin
    logic        v, ordy, fl, pt;
    logic [1:0]  ex;
    logic [31:0] pc, inst, tgt;

    // Reset
    idle_inputs();
    rstn = 1'b0;
    #12;
    chk("rst_count", 99'(count), 99'd0);
    chk("rst_out_valid", 99'(out_valid), 99'd0);
    chk("rst_in_ready", 99'(in_ready), 99'd1);
    chk("rst_out_pc", 99'(out_pc), 99'd0);
    chk("rst_out_inst", 99'(out_inst), 99'd0);
    chk("rst_out_target", 99'(out_pred_target), 99'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single push, visible next cycle, then pop
    push(32'h1c00_0000, 32'h0280_0421, 1'b0);
    chk("t1_pc", 99'(out_pc), 99'h1c00_0000);
    chk("t1_inst", 99'(out_inst), 99'h0280_0421);
    wait_cycle(1'b1);
    chk("t1_empty", 99'(out_valid), 99'd0);

    // Fill to DEPTH, refuse extra beat, push+pop while full pops only
    for (int k = 0; k < DEPTH; k++) push(32'h1c00_1000 + 32'(4 * k), $urandom, 1'b0);
    chk("t2_full_ready", 99'(in_ready), 99'd0);
    push(32'h1c00_2000, 32'hdead_beef, 1'b0);
    chk("t2_full_count", 99'(count), 99'd8);
    push(32'h1c00_2004, 32'hdead_beef, 1'b1);
    chk("t2_pushpop_count", 99'(count), 99'd7);
    chk("t2_pushpop_head", 99'(out_pc), 99'h1c00_1004);
    for (int k = 0; k < DEPTH; k++) wait_cycle(1'b1);

    // Steady push+pop for 20 beats: count stays 1, order preserved across wraps
    push(32'h1c00_0000, $urandom, 1'b0);
    for (int k = 1; k <= 20; k++) push(32'h1c00_0000 + 32'(4 * k), $urandom, 1'b1);
    chk("t3_count", 99'(count), 99'd1);
    chk("t3_last_pc", 99'(out_pc), 99'h1c00_0050);
    wait_cycle(1'b1);

    // Fill 5, flush with a push and pop offered: everything discarded
    for (int k = 0; k < 5; k++) push(32'h1c00_3000 + 32'(4 * k), $urandom, 1'b0);
    beat(1'b1, 32'h1c00_3fff, 32'h1234_5678, 1'b0, 32'd0, 2'd0, 1'b1, 1'b1);
    chk("t4_count", 99'(count), 99'd0);
    chk("t4_valid", 99'(out_valid), 99'd0);
    push(32'h1c00_4000, 32'h0000_0001, 1'b0);
    chk("t4_next_pc", 99'(out_pc), 99'h1c00_4000);
    wait_cycle(1'b1);
    // Flush while empty is harmless
    beat(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 2'd0, 1'b0, 1'b1);

    // Exception entry: instruction zeroed, prediction passed through
    beat(1'b1, 32'h1c00_5000, 32'h0010_0000, 1'b1, 32'h1c00_6000, 2'd1, 1'b0, 1'b0);
    chk("t5_excp", 99'(out_excp), 99'd1);
    chk("t5_inst", 99'(out_inst), 99'd0);
    chk("t5_taken", 99'(out_pred_taken), 99'd1);
    chk("t5_target", 99'(out_pred_target), 99'h1c00_6000);
    wait_cycle(1'b1);

    // Asynchronous reset mid-cycle with 3 entries held
    for (int k = 0; k < 3; k++) push(32'h1c00_7000 + 32'(4 * k), $urandom, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_count", 99'(count), 99'd0);
    chk("t6_valid", 99'(out_valid), 99'd0);
    chk("t6_ready", 99'(in_ready), 99'd1);
    chk("t6_pc", 99'(out_pc), 99'd0);
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 31) == 0);
      pc   = $urandom;
      inst = $urandom;
      pt   = 1'($urandom_range(0, 1));
      tgt  = $urandom;
      ex   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      beat(v, pc, inst, pt, tgt, ex, ordy, fl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
